rom32x4_arb: RTL

ROM32X4_ARB -- requirements
Module: rom32x4_arb

---
 rtl/rom32x4_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rom32x4_arb.sv
// Two-port burst read arbiter in front of a 32x4 ROM with a registered output.
// Grants one burst at a time and returns data tagged to its owner two cycles after issue.
module rom32x4_arb #(
  parameter string ARB_MODE = "ROUND_ROBIN"
) (
  input  logic       ck,
  input  logic       rstn,
  input  logic       req0,
  input  logic       req1,
  input  logic [4:0] adr0,
  input  logic [4:0] adr1,
  input  logic [1:0] len0,
  input  logic [1:0] len1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       vld0,
  output logic       vld1,
  output logic [3:0] dat0,
  output logic [3:0] dat1,
  output logic [4:0] rad,
  input  logic [3:0] rqdo,
  output logic       busy
);

  localparam int   DATA_W    = 4;
  localparam int   ADDR_W    = 5;
  localparam logic FIXED_PRI = (ARB_MODE == "FIXED");

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_n;
  logic [1:0]          cnt, cnt_n;
  logic                own, own_n;
  logic                pri, pri_n;
  logic [ADDR_W-1:0]   rad_n;
  logic                gnt0_n, gnt1_n;
  logic                issue;
  logic                win;

  logic                vld_p0, own_p0;
  logic                vld_p1, own_p1;

  // Sequential ROM address; 31 rolls over to 0.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // A lone requester always wins; contention is resolved by policy.
  function automatic logic pick(input logic r0, input logic r1, input logic p);
    if (r0 && r1)
      return FIXED_PRI ? 1'b0 : p;
    return r1;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    own_n   = own;
    pri_n   = pri;
    rad_n   = rad;
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    issue   = 1'b0;
    win     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          win    = pick(req0, req1, pri);
          issue  = 1'b1;
          own_n  = win;
          gnt0_n = ~win;
          gnt1_n = win;
          rad_n  = win ? adr1 : adr0;
          cnt_n  = win ? len1 : len0;
          if (req0 && req1 && !FIXED_PRI)
            pri_n = ~pri;
          state_n = (cnt_n == 2'd0) ? IDLE : BURST;
        end
      end
      BURST: begin
        issue = 1'b1;
        rad_n = next_addr(rad);
        cnt_n = cnt - 2'd1;
        if (cnt == 2'd1)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage 0: arbitration, address issue and burst bookkeeping.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      own    <= 1'b0;
      pri    <= 1'b0;
      rad    <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      vld_p0 <= 1'b0;
      own_p0 <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      own    <= own_n;
      pri    <= pri_n;
      rad    <= rad_n;
      gnt0   <= gnt0_n;
      gnt1   <= gnt1_n;
      vld_p0 <= issue;
      own_p0 <= own_n;
    end
  end

  // Stage 1: the ROM latches the issued address this edge.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      own_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      own_p1 <= own_p0;
    end
  end

  // Stage 2: steer ROM data to its owner; idle ports keep their last word.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      vld0 <= 1'b0;
      vld1 <= 1'b0;
      dat0 <= '0;
      dat1 <= '0;
    end else begin
      vld0 <= vld_p1 & ~own_p1;
      vld1 <= vld_p1 & own_p1;
      if (vld_p1 && !own_p1)
        dat0 <= rqdo[DATA_W-1:0];
      if (vld_p1 && own_p1)
        dat1 <= rqdo[DATA_W-1:0];
    end
  end

  assign busy = (state == BURST);

endmodule
